// File: rtl/stream_demux_router_if.sv
// Handshake bundle between a stream source, the demux router and its N_CH consumers.
// slave is the router's view; master is the view of whoever drives the stream and consumers.
interface stream_demux_router_if #(
  parameter int DATA_W = 4,
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) ();
  logic                     en;
  logic                     mode;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_CH*DATA_W-1:0]   out_data;
  logic [N_CH-1:0]          out_valid;
  logic [N_CH-1:0]          out_ready;
  logic [CNT_W-1:0]         drop_cnt;

  modport slave (
    input  en, mode, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_cnt
  );

  modport master (
    output en, mode, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_cnt
  );
endinterface

// File: rtl/stream_demux_router.sv
// 1:N_CH valid/ready demux with broadcast, one-entry register per channel, 1-cycle latency.
// in_ready is combinational from out_ready/mode/en/in_sel; bad selects are sunk and counted.
module stream_demux_router #(
  parameter int DATA_W = 4,
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_demux_router_if.slave bus
);

  logic [N_CH-1:0]              valid_q;
  logic [N_CH-1:0][DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]             drop_q;

  logic [N_CH-1:0] free;
  logic [N_CH-1:0] sel_hit;
  logic            sel_ok;
  logic            ready;
  logic            acc;
  logic            drop;
  logic [N_CH-1:0] load;

  assign free = ~valid_q | bus.out_ready;

  // One-hot decode avoids indexing past N_CH when in_sel is out of range.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_hit[i] = (int'(bus.in_sel) == i);
    end
  end

  assign sel_ok = |sel_hit;

  always_comb begin
    ready = 1'b0;
    if (bus.en) begin
      if (bus.mode) begin
        ready = &free;
      end else if (sel_ok) begin
        ready = |(sel_hit & free);
      end else begin
        ready = 1'b1;
      end
    end
  end

  assign acc  = bus.in_valid & ready;
  assign drop = acc & ~bus.mode & ~sel_ok;

  always_comb begin
    load = '0;
    for (int i = 0; i < N_CH; i++) begin
      load[i] = acc & (bus.mode | sel_hit[i]);
    end
  end

  // A load takes priority over a drain on the same lane, giving full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load[i]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= bus.in_data;
        end else if (valid_q[i] && bus.out_ready[i]) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux_router.sv
// Directed bench: vector table on an 8-channel router, hand sequences on a 6-channel one.
module tb_stream_demux_router;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_router_if #(.DATA_W(4), .N_CH(8), .SEL_W(3), .CNT_W(8)) b8 ();
  stream_demux_router_if #(.DATA_W(4), .N_CH(6), .SEL_W(3), .CNT_W(8)) b6 ();

  stream_demux_router #(.DATA_W(4), .N_CH(8), .SEL_W(3), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .bus(b8.slave)
  );
  stream_demux_router #(.DATA_W(4), .N_CH(6), .SEL_W(3), .CNT_W(8)) u6 (
    .clk(clk), .rst(rst), .bus(b6.slave)
  );

  typedef struct {
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  data;
    logic        valid;
    logic [7:0]  oready;
    logic        exp_ready;
    logic [7:0]  exp_valid;
    logic [31:0] exp_data;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic mode, input logic [2:0] sel,
                     input logic [3:0] data, input logic valid, input logic [7:0] oready,
                     input logic exp_ready, input logic [7:0] exp_valid,
                     input logic [31:0] exp_data);
    vec_t v;
    v.en = en; v.mode = mode; v.sel = sel; v.data = data; v.valid = valid;
    v.oready = oready; v.exp_ready = exp_ready; v.exp_valid = exp_valid;
    v.exp_data = exp_data; v.exp_drop = 8'd0;
    vq.push_back(v);
  endtask

  task automatic drive8(input logic en, input logic mode, input logic [2:0] sel,
                        input logic [3:0] data, input logic valid, input logic [7:0] oready);
    b8.en = en; b8.mode = mode; b8.in_sel = sel; b8.in_data = data;
    b8.in_valid = valid; b8.out_ready = oready;
  endtask

  task automatic drive6(input logic en, input logic [2:0] sel, input logic [3:0] data,
                        input logic valid);
    b6.en = en; b6.mode = 1'b0; b6.in_sel = sel; b6.in_data = data;
    b6.in_valid = valid; b6.out_ready = 6'h3f;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // unicast sweep, all consumers ready
    add(1, 0, 3'd0, 4'hA, 1, 8'hFF, 1, 8'h01, 32'h0000_000A);
    add(1, 0, 3'd1, 4'hB, 1, 8'hFF, 1, 8'h02, 32'h0000_00B0);
    add(1, 0, 3'd2, 4'hC, 1, 8'hFF, 1, 8'h04, 32'h0000_0C00);
    add(1, 0, 3'd3, 4'hD, 1, 8'hFF, 1, 8'h08, 32'h0000_D000);
    add(1, 0, 3'd4, 4'hE, 1, 8'hFF, 1, 8'h10, 32'h000E_0000);
    add(1, 0, 3'd5, 4'hF, 1, 8'hFF, 1, 8'h20, 32'h00F0_0000);
    add(1, 0, 3'd6, 4'h1, 1, 8'hFF, 1, 8'h40, 32'h0100_0000);
    add(1, 0, 3'd7, 4'h2, 1, 8'hFF, 1, 8'h80, 32'h2000_0000);
    add(1, 0, 3'd0, 4'h0, 0, 8'hFF, 1, 8'h00, 32'h0000_0000);
    // backpressure on ch3, then drain and refill at the same edge
    add(1, 0, 3'd3, 4'h5, 1, 8'hF7, 1, 8'h08, 32'h0000_5000);
    add(1, 0, 3'd3, 4'h6, 1, 8'hF7, 0, 8'h08, 32'h0000_5000);
    add(1, 0, 3'd3, 4'h6, 1, 8'hF7, 0, 8'h08, 32'h0000_5000);
    add(1, 0, 3'd3, 4'h6, 1, 8'hFF, 1, 8'h08, 32'h0000_6000);
    add(1, 0, 3'd3, 4'h6, 0, 8'hFF, 1, 8'h00, 32'h0000_0000);
    // broadcast blocked by a stalled ch2, then released
    add(1, 0, 3'd2, 4'h7, 1, 8'hFB, 1, 8'h04, 32'h0000_0700);
    add(1, 1, 3'd5, 4'hC, 1, 8'hFB, 0, 8'h04, 32'h0000_0700);
    add(1, 1, 3'd5, 4'hC, 1, 8'hFF, 1, 8'hFF, 32'hCCCC_CCCC);
    add(1, 1, 3'd5, 4'hC, 0, 8'hFF, 1, 8'h00, 32'h0000_0000);
    // intake disabled while ch1 drains
    add(1, 0, 3'd1, 4'h9, 1, 8'h00, 1, 8'h02, 32'h0000_0090);
    add(0, 0, 3'd1, 4'h3, 1, 8'h02, 0, 8'h00, 32'h0000_0000);
    add(0, 1, 3'd1, 4'h3, 1, 8'hFF, 0, 8'h00, 32'h0000_0000);

    // reset held 2 cycles with valid input present
    rst = 1'b1;
    drive8(1, 0, 3'd0, 4'hF, 1, 8'h00);
    drive6(1, 3'd7, 4'hF, 1);
    repeat (2) edge1();
    chk("rst_valid8", b8.out_valid, 0);
    chk("rst_data8",  b8.out_data, 0);
    chk("rst_drop8",  b8.drop_cnt, 0);
    chk("rst_valid6", b6.out_valid, 0);
    chk("rst_drop6",  b6.drop_cnt, 0);
    drive8(1, 0, 3'd0, 4'h0, 0, 8'hFF);
    drive6(1, 3'd0, 4'h0, 0);
    rst = 1'b0;

    foreach (vq[k]) begin
      drive8(vq[k].en, vq[k].mode, vq[k].sel, vq[k].data, vq[k].valid, vq[k].oready);
      #1;
      chk($sformatf("v%0d_in_ready", k), b8.in_ready, vq[k].exp_ready);
      edge1();
      chk($sformatf("v%0d_out_valid", k), b8.out_valid, vq[k].exp_valid);
      chk($sformatf("v%0d_out_data", k),  b8.out_data,  vq[k].exp_data);
      chk($sformatf("v%0d_drop_cnt", k),  b8.drop_cnt,  vq[k].exp_drop);
    end
    drive8(1, 0, 3'd0, 4'h0, 0, 8'hFF);

    // 6-channel: first out-of-range select (6) then 299 more with select 7
    drive6(1, 3'd6, 4'h3, 1);
    #1;
    chk("bad6_in_ready", b6.in_ready, 1);
    edge1();
    chk("bad6_drop", b6.drop_cnt, 1);
    chk("bad6_valid", b6.out_valid, 0);
    drive6(1, 3'd7, 4'h4, 1);
    for (int j = 1; j <= 299; j++) begin
      #1;
      if (b6.in_ready !== 1'b1) chk("bad7_in_ready", b6.in_ready, 1);
      edge1();
      if (j == 253) chk("drop_254", b6.drop_cnt, 254);
      if (j == 254) chk("drop_255", b6.drop_cnt, 255);
    end
    chk("drop_sat", b6.drop_cnt, 255);
    chk("bad_no_valid", b6.out_valid, 0);
    drive6(1, 3'd5, 4'h9, 1);
    #1;
    chk("top6_in_ready", b6.in_ready, 1);
    edge1();
    chk("top6_valid", b6.out_valid, 6'h20);
    chk("top6_data", b6.out_data, 24'h90_0000);
    chk("top6_drop", b6.drop_cnt, 255);
    drive6(1, 3'd0, 4'h0, 0);

    // mid-operation reset discards a stalled payload and blocks a pending load
    drive8(1, 0, 3'd4, 4'h8, 1, 8'h00);
    edge1();
    chk("pre_rst_valid", b8.out_valid, 8'h10);
    drive8(1, 0, 3'd0, 4'h1, 1, 8'h00);
    rst = 1'b1;
    edge1();
    chk("mid_rst_valid8", b8.out_valid, 0);
    chk("mid_rst_data8", b8.out_data, 0);
    chk("mid_rst_valid6", b6.out_valid, 0);
    chk("mid_rst_drop6", b6.drop_cnt, 0);
    rst = 1'b0;
    drive8(1, 0, 3'd0, 4'h0, 0, 8'hFF);
    edge1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
